// File: rtl/ctrl_seq_pkg.sv
// Shared state encoding for the ONC-16 control sequencer.
package ctrl_seq_pkg;

    localparam int SEQ_ST_W = 3;

    // Codes 6-7 are unused; the sequencer recovers from them to IDLE.
    typedef enum logic [SEQ_ST_W-1:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_WB     = 3'd5
    } seq_st_e;

endpackage

// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer; 4 cycles per ALU op, 5 per LD/ST with zero-wait memory.
// Stalls in FETCH/MEM until the memory acks; run=0 only takes effect at an instruction boundary.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                imem_req,
    input  logic                imem_ack,
    output logic                ir_we,
    input  logic                dec_rf_we,
    input  logic                dec_fr_de,
    input  logic                dec_dmem_we,
    input  logic                dec_mem_rd,
    output logic                dmem_req,
    input  logic                dmem_ack,
    output logic                dmem_we,
    output logic                fr_de,
    output logic                rf_we,
    output logic                pc_we,
    output logic                busy,
    output logic [SEQ_ST_W-1:0] state,
    output logic [CNT_W-1:0]    instret
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_st_e state_q;
    seq_st_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SEQ_WB) begin
                instret <= instret + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        fr_de    = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (run) state_d = SEQ_FETCH;
            end
            SEQ_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = SEQ_DECODE;
                end
            end
            SEQ_DECODE: begin
                state_d = SEQ_EXEC;
            end
            SEQ_EXEC: begin
                fr_de   = dec_fr_de;
                state_d = (dec_mem_rd | dec_dmem_we) ? SEQ_MEM : SEQ_WB;
            end
            SEQ_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_dmem_we;
                if (dmem_ack) state_d = SEQ_WB;
            end
            SEQ_WB: begin
                rf_we   = dec_rf_we;
                pc_we   = 1'b1;
                state_d = run ? SEQ_FETCH : SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
        // An ack landing in a reset cycle must not commit anything.
        if (rst) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            fr_de    = 1'b0;
            rf_we    = 1'b0;
            pc_we    = 1'b0;
        end
    end

    assign busy  = (state_q != SEQ_IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed cycle-by-cycle table for ctrl_seq plus a long counter-wrap run.
module tb_ctrl_seq;

    localparam int TB_CNT_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                run;
    logic                imem_req;
    logic                imem_ack;
    logic                ir_we;
    logic                dec_rf_we;
    logic                dec_fr_de;
    logic                dec_dmem_we;
    logic                dec_mem_rd;
    logic                dmem_req;
    logic                dmem_ack;
    logic                dmem_we;
    logic                fr_de;
    logic                rf_we;
    logic                pc_we;
    logic                busy;
    logic [2:0]          state;
    logic [TB_CNT_W-1:0] instret;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ctrl_seq #(.CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .ir_we       (ir_we),
        .dec_rf_we   (dec_rf_we),
        .dec_fr_de   (dec_fr_de),
        .dec_dmem_we (dec_dmem_we),
        .dec_mem_rd  (dec_mem_rd),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .dmem_we     (dmem_we),
        .fr_de       (fr_de),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .busy        (busy),
        .state       (state),
        .instret     (instret)
    );

    // in  = {rst, run, imem_ack, dmem_ack, dec_rf_we, dec_fr_de, dec_dmem_we, dec_mem_rd}
    // out = {imem_req, ir_we, dmem_req, dmem_we, fr_de, rf_we, pc_we, busy}
    typedef struct {
        logic [7:0] in;
        logic [2:0] st;
        logic [7:0] out;
        logic [7:0] ic;
    } vec_t;

    localparam int NV = 36;
    vec_t tbl [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and ADD (rf_we, fr_de), zero wait.
        tbl[0]  = '{8'b1000_0000, 3'd0, 8'b0000_0000, 8'd0};
        tbl[1]  = '{8'b0100_1100, 3'd0, 8'b0000_0000, 8'd0};
        tbl[2]  = '{8'b0110_1100, 3'd1, 8'b1100_0001, 8'd0};
        tbl[3]  = '{8'b0100_1100, 3'd2, 8'b0000_0001, 8'd0};
        tbl[4]  = '{8'b0100_1100, 3'd3, 8'b0000_1001, 8'd0};
        tbl[5]  = '{8'b0100_1100, 3'd5, 8'b0000_0111, 8'd0};
        // LD with dmem_ack three cycles late.
        tbl[6]  = '{8'b0110_1001, 3'd1, 8'b1100_0001, 8'd1};
        tbl[7]  = '{8'b0100_1001, 3'd2, 8'b0000_0001, 8'd1};
        tbl[8]  = '{8'b0100_1001, 3'd3, 8'b0000_0001, 8'd1};
        tbl[9]  = '{8'b0100_1001, 3'd4, 8'b0010_0001, 8'd1};
        tbl[10] = '{8'b0100_1001, 3'd4, 8'b0010_0001, 8'd1};
        tbl[11] = '{8'b0100_1001, 3'd4, 8'b0010_0001, 8'd1};
        tbl[12] = '{8'b0101_1001, 3'd4, 8'b0010_0001, 8'd1};
        tbl[13] = '{8'b0100_1001, 3'd5, 8'b0000_0111, 8'd1};
        // ST, one imem wait, spurious acks in DECODE/EXEC, one dmem wait.
        tbl[14] = '{8'b0100_0010, 3'd1, 8'b1000_0001, 8'd2};
        tbl[15] = '{8'b0110_0010, 3'd1, 8'b1100_0001, 8'd2};
        tbl[16] = '{8'b0101_0010, 3'd2, 8'b0000_0001, 8'd2};
        tbl[17] = '{8'b0110_0010, 3'd3, 8'b0000_0001, 8'd2};
        tbl[18] = '{8'b0100_0010, 3'd4, 8'b0011_0001, 8'd2};
        tbl[19] = '{8'b0101_0010, 3'd4, 8'b0011_0001, 8'd2};
        tbl[20] = '{8'b0100_0010, 3'd5, 8'b0000_0011, 8'd2};
        // ADD with run dropping in EXEC: completes, then parks in IDLE.
        tbl[21] = '{8'b0110_1100, 3'd1, 8'b1100_0001, 8'd3};
        tbl[22] = '{8'b0100_1100, 3'd2, 8'b0000_0001, 8'd3};
        tbl[23] = '{8'b0000_1100, 3'd3, 8'b0000_1001, 8'd3};
        tbl[24] = '{8'b0000_1100, 3'd5, 8'b0000_0111, 8'd3};
        tbl[25] = '{8'b0000_1100, 3'd0, 8'b0000_0000, 8'd4};
        tbl[26] = '{8'b0010_1100, 3'd0, 8'b0000_0000, 8'd4};
        // Reset colliding with imem_ack.
        tbl[27] = '{8'b0100_1100, 3'd0, 8'b0000_0000, 8'd4};
        tbl[28] = '{8'b1110_1100, 3'd1, 8'b0000_0001, 8'd4};
        tbl[29] = '{8'b0000_1100, 3'd0, 8'b0000_0000, 8'd0};
        // Reset colliding with dmem_ack on a store.
        tbl[30] = '{8'b0100_0010, 3'd0, 8'b0000_0000, 8'd0};
        tbl[31] = '{8'b0110_0010, 3'd1, 8'b1100_0001, 8'd0};
        tbl[32] = '{8'b0100_0010, 3'd2, 8'b0000_0001, 8'd0};
        tbl[33] = '{8'b0100_0010, 3'd3, 8'b0000_0001, 8'd0};
        tbl[34] = '{8'b1101_0010, 3'd4, 8'b0000_0001, 8'd0};
        tbl[35] = '{8'b0000_0010, 3'd0, 8'b0000_0000, 8'd0};

        {rst, run, imem_ack, dmem_ack, dec_rf_we, dec_fr_de, dec_dmem_we, dec_mem_rd} = 8'b1000_0000;
        repeat (2) step();

        for (int i = 0; i < NV; i++) begin
            {rst, run, imem_ack, dmem_ack, dec_rf_we, dec_fr_de, dec_dmem_we, dec_mem_rd} = tbl[i].in;
            @(negedge clk);
            check("state", i, 32'(state), 32'(tbl[i].st));
            check("outs", i, 32'({imem_req, ir_we, dmem_req, dmem_we, fr_de, rf_we, pc_we, busy}),
                  32'(tbl[i].out));
            check("instret", i, 32'(instret), 32'(tbl[i].ic));
            step();
        end

        // Back-to-back ADDs up to the counter's all-ones value, then wrap.
        begin
            int pc_cnt;
            int rf_cnt;
            pc_cnt = 0;
            rf_cnt = 0;
            {rst, run, imem_ack, dmem_ack, dec_rf_we, dec_fr_de, dec_dmem_we, dec_mem_rd} = 8'b0110_1100;
            for (int c = 0; c < 1 + 4 * 255; c++) begin
                @(negedge clk);
                pc_cnt += int'(pc_we);
                rf_cnt += int'(rf_we);
                step();
            end
            @(negedge clk);
            check("instret_max", 0, 32'(instret), 32'd255);
            check("state_max", 0, 32'(state), 32'd1);
            check("pc_we_count", 0, 32'(pc_cnt), 32'd255);
            check("rf_we_count", 0, 32'(rf_cnt), 32'd255);
            repeat (4) step();
            @(negedge clk);
            check("instret_wrap", 0, 32'(instret), 32'd0);
            check("state_wrap", 0, 32'(state), 32'd1);
        end

        // Drop run for the in-flight instruction; it retires and the fetcher stays quiet.
        run = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("stop_state", 0, 32'(state), 32'd0);
        check("stop_busy", 0, 32'(busy), 32'd0);
        check("stop_imem_req", 0, 32'(imem_req), 32'd0);
        check("stop_instret", 0, 32'(instret), 32'd1);
        step();
        @(negedge clk);
        check("idle_imem_req", 1, 32'(imem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Multi-cycle control sequencer for the ONC-16 core. It steps each instruction through fetch, decode, execute, optional memory access and write-back. It handshakes with instruction and data memory and turns the decoder's static enables (`rf_we`, `dmem_we`, `fr_de`) into single-cycle strobes at the correct phase. It sits between the decoder and the register file, flag register, PC and memories, and keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; everything is updated on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  instruction word valid this cycle.
- `ir_we`  out  1  latch the instruction register.
- `dec_rf_we`  in  1  decoder `rf_we`.
- `dec_fr_de`  in  1  decoder `fr_de`.
- `dec_dmem_we`  in  1  decoder `dmem_we` (ST).
- `dec_mem_rd`  in  1  instruction reads data memory (LD); derived from `rf_w_sel` at the top level.
- `dmem_req`  out  1  data memory request.
- `dmem_ack`  in  1  data access complete; read data valid this cycle.
- `dmem_we`  out  1  data memory write strobe.
- `fr_de`  out  1  flag register write strobe.
- `rf_we`  out  1  register file write strobe.
- `pc_we`  out  1  PC update strobe; the source is selected by `pc_imr_sel`.
- `busy`  out  1  high when state ≠ IDLE.
- `state`  out  `SEQ_ST_W`  current state, for debug.
- `instret`  out  `CNT_W`  number of retired instructions.

## Operation
States:
- IDLE
- FETCH
- DECODE
- EXEC
- MEM
- WB

Transitions:
- IDLE → FETCH when `run`=1.
- FETCH: `imem_req`=1 and is held until `imem_ack`. In the ack cycle `ir_we`=1, then → DECODE.
- DECODE: lasts one cycle so the decoder can settle on the new IR. No strobes. → EXEC.
- EXEC: `fr_de`=`dec_fr_de`. Next state is MEM if `dec_mem_rd|dec_dmem_we`, otherwise WB.
- MEM: `dmem_req`=1 and is held until `dmem_ack`. `dmem_we`=`dec_dmem_we & dmem_req` for every MEM cycle. On ack → WB.
- WB: `rf_we`=`dec_rf_we` and `pc_we`=1. `instret` increments and wraps modulo 2^`CNT_W`. Then → FETCH if `run`=1, else → IDLE.

Output and control rules:
- Outputs are a combinational decode of `state` and the `dec_*` inputs and acks.
- Every output strobe is additionally gated by `~rst`.
- `run`=0 never aborts an instruction in flight. It is sampled only in IDLE and WB.
- Decoder inputs must stay stable from DECODE through WB, because the IR only changes on `ir_we`.

## Timing
- Reset: on a `clk` edge with `rst`=1, state → IDLE and `instret` → 0. All outputs read 0 from then until the first FETCH.
- Reset mid-operation:
  - Any state goes to IDLE on the next edge.
  - An ack arriving in the same cycle as `rst` produces no `ir_we`, `rf_we` or `dmem_we`.
  - `rst` has priority over `run`.
- Latency with zero-wait memories:
  - ALU, immediate and branch instructions take 4 cycles (FETCH, DECODE, EXEC, WB).
  - LD and ST take 5 cycles.
  - Each extra cycle of `imem_ack` or `dmem_ack` delay adds one cycle.
- Strobe widths: `ir_we`, `fr_de`, `rf_we`, `pc_we` and `instret` increments each last exactly one cycle per instruction. A load's `rf_we` comes one cycle after `dmem_ack`.
- Spurious acks: `imem_ack` outside FETCH and `dmem_ack` outside MEM are ignored.
- `instret` wraps from 0xFFFF to 0x0000 with no other effect.

## Structure
- The following constants go in `def.v`:
  - `SEQ_ST_W` = 3.
  - State codes `SEQ_IDLE`=0, `SEQ_FETCH`=1, `SEQ_DECODE`=2, `SEQ_EXEC`=3, `SEQ_MEM`=4, `SEQ_WB`=5.
  - Codes 6–7 are illegal and go to IDLE.
- No sub-module. The state register, next-state logic and `instret` counter live inline in `ctrl_seq`.

## Test plan
- Reset, then `run`=1 with zero-wait memories and an ADD instruction (`dec_rf_we`=1, `dec_fr_de`=1) → state sequence 1,2,3,5,1. `fr_de` is high in cycle 3, `rf_we` and `pc_we` in cycle 4, and `instret`=1.
- LD (`dec_mem_rd`=1) with `dmem_ack` delayed 3 cycles → `dmem_req` is high for 4 cycles with `dmem_we`=0. `rf_we` pulses one cycle after the ack. Total 8 cycles.
- ST (`dec_dmem_we`=1, `dec_rf_we`=0) → `dmem_we` equals `dmem_req` for the whole of MEM and `rf_we` stays 0 throughout.
- `run` drops during EXEC → the instruction completes through WB, the sequencer enters IDLE, `busy`=0, and `imem_req` is not reasserted.
- `rst` asserted in the same cycle as `imem_ack` → `ir_we`=0. On the next cycle state=0 and all outputs are 0.
- Preload `instret`=0xFFFF by running 65535 instructions, then retire one more → `instret`=0x0000.
